pulse_period_meter: RTL and testbench
=====================================

# pulse_period_meter

Receive-side companion to the programmable pulse divider. It samples a one-cycle pulse train and measures the number of clock cycles between consecutive pulses. The result is reported in the same 8-bit encoding used for the divider's period setting, so a period of 256 reads as 0. It also counts received pulses modulo 128 and flags lock when the period is stable. Its output is intended for loop-back checking of the divider on the same die.

## Interface
- CNT_W, 8: width of the period counter and of `period_out`. The maximum measurable period is 2^CNT_W.
- EVT_W, 7: width of the event counter.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high reset.
- `pulse_in` input 1: pulse train. Every cycle in which it is sampled high is one event.
- `period_out` output CNT_W: last valid measured period, modulo 2^CNT_W. Reset value 0.
- `period_valid` output 1: one-cycle strobe that fires when `period_out` is updated. Reset value 0.
- `period_err` output 1: one-cycle strobe that fires when a measured period exceeded 2^CNT_W. Reset value 0.
- `locked` output 1: two consecutive valid periods were equal. Reset value 0.
- `event_count` output EVT_W: number of events received, wrapping from 2^EVT_W−1 to 0. Reset value 0.

## Operation
- Event detection: an event (`ev`) is `pulse_in` sampled high at a rising edge of `clk`. The input is level-sampled, not edge-detected, so a constantly high input produces one event per cycle (period 1).
- State machine: two states, IDLE and MEASURE. Reset places it in IDLE.
  - IDLE: on `ev`, move to MEASURE, set `cnt` to 0 and clear `ovf`. No strobe is issued.
  - MEASURE, without `ev`: if `cnt` equals 2^CNT_W−1, set `ovf` and hold `cnt`. Otherwise increment `cnt`.
  - MEASURE, with `ev` and `ovf`=0: load `period_out` with (`cnt`+1) truncated to CNT_W bits and pulse `period_valid`.
  - MEASURE, with `ev` and `ovf`=1: pulse `period_err`, leave `period_out` unchanged and clear `locked`.
  - MEASURE, with `ev`, in both cases: set `cnt` to 0, clear `ovf` and stay in MEASURE.
- Lock detection: keep `prev_period` and `have_prev`, both cleared on reset and on `period_err`.
  - On a valid period: `locked` is set to 1 if `have_prev` is 1 and the new period equals `prev_period`, and set to 0 otherwise.
  - Then `prev_period` takes the new period and `have_prev` is set to 1.
- Event counter: `event_count` increments on every `ev` in either state and wraps from 127 to 0.
- Period encoding: period 256 reports as `period_out`=0. Periods 1 to 255 report as themselves.
- Reset precedence: reset has priority over a simultaneous `ev`. Reset in the middle of a measurement discards the partial count. After reset the block needs one event to arm, two events for the first `period_valid`, and three equal-spaced events for `locked`.

## Timing
- Without the synchronizer, `pulse_in` high before edge k gives `period_out`, `period_valid` or `period_err`, and `event_count` updated right after edge k. Latency is one edge.
- `locked` updates on the same edge as the `period_valid` that decides it.
- Strobes are high for exactly one cycle. With period 1, `period_valid` stays high continuously, because it is re-asserted every cycle.
- All outputs are registered. There are no combinational paths from input to output.
- There is no backpressure. The consumer must sample `period_out` while `period_valid` is high, or at any later cycle before the next strobe.

## Configuration
- Macro: `PULSE_PERIOD_SYNC_EN`.
- Defined: `pulse_in` passes through a two-flop synchronizer before event detection, for sources that are asynchronous to `clk`. Event-to-output latency becomes three edges. Measured periods are unchanged. The synchronizer flops clear on reset.
- Undefined: `pulse_in` is sampled directly. The source must be synchronous to `clk`, and latency is one edge.

## Test plan
- Events every 5 cycles after reset → no strobe on event 1. Event 2 gives `period_out`=5 with `period_valid`. Event 3 gives `locked`=1. `event_count` equals 3.
- `pulse_in` held high for 10 cycles → `period_valid` high on cycles 2 to 10 with `period_out`=1. `locked` rises on cycle 3. `event_count`=10.
- Events 256 cycles apart → `period_out`=0 with `period_valid` and no `period_err`. Then a 300-cycle gap → `period_err` pulses, `period_out` stays 0, `locked` drops.
- Locked at period 7, then one period of 9 → `period_out`=9 and `locked`=0. Next period of 9 → `locked`=1.
- 130 events at period 3 → `event_count` wraps from 127 to 0 and ends at 2. `period_out` stays 3 throughout.
- Reset asserted mid-period, coincident with an event → all outputs are 0 and the event is not counted. Then two events 4 cycles apart → `period_out`=4. Repeat with `PULSE_PERIOD_SYNC_EN` defined and check the output occurs two cycles later.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Measures the clock-cycle spacing of a pulse train, counts events and flags lock on a stable period.
// Optional macro PULSE_PERIOD_SYNC_EN adds a two-flop input synchronizer (latency grows by two edges).
module pulse_period_meter #(
  parameter int CNT_W = 8,
  parameter int EVT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             period_err,
  output logic             locked,
  output logic [EVT_W-1:0] event_count
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] periodOut_q, periodOut_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] prevPeriod_q, prevPeriod_d;
  logic             havePrev_q, havePrev_d;
  logic [EVT_W-1:0] eventCount_q, eventCount_d;
  logic [CNT_W-1:0] newPeriod;
  logic             ev;

`ifdef PULSE_PERIOD_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
    end
  end

  assign ev = sync2_q;
`else
  assign ev = pulse_in;
`endif

  // Truncation makes a full 2^CNT_W period read back as 0, matching the divider encoding.
  assign newPeriod = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    periodOut_d  = periodOut_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    locked_d     = locked_q;
    prevPeriod_d = prevPeriod_q;
    havePrev_d   = havePrev_q;
    eventCount_d = ev ? eventCount_q + EVT_W'(1) : eventCount_q;

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = MEASURE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (ev) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          if (ovf_q) begin
            err_d        = 1'b1;
            locked_d     = 1'b0;
            prevPeriod_d = '0;
            havePrev_d   = 1'b0;
          end else begin
            periodOut_d  = newPeriod;
            valid_d      = 1'b1;
            locked_d     = havePrev_q && (newPeriod == prevPeriod_q);
            prevPeriod_d = newPeriod;
            havePrev_d   = 1'b1;
          end
        end else if (cnt_q == '1) begin
          // Saturate so any longer gap is reported as an error, not a wrapped period.
          ovf_d = 1'b1;
        end else begin
          cnt_d = newPeriod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      periodOut_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      prevPeriod_q <= '0;
      havePrev_q   <= 1'b0;
      eventCount_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      periodOut_q  <= periodOut_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
      prevPeriod_q <= prevPeriod_d;
      havePrev_q   <= havePrev_d;
      eventCount_q <= eventCount_d;
    end
  end

  assign period_out   = periodOut_q;
  assign period_valid = valid_q;
  assign period_err   = err_q;
  assign locked       = locked_q;
  assign event_count  = eventCount_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: a timestamp-based reference model predicts each strobe
// and a monitor compares strobes as they appear, independent of pipeline latency.
module tb_pulse_period_meter;

  localparam int CNT_W = 8;
  localparam int EVT_W = 7;
`ifdef PULSE_PERIOD_SYNC_EN
  localparam int LAT_EXTRA = 2;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             pulse_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             period_err;
  logic             locked;
  logic [EVT_W-1:0] event_count;

  pulse_period_meter #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .period_err   (period_err),
    .locked       (locked),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [7:0] period;
    logic       lock;
    logic [6:0] evCnt;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;

  // Reference model: periods come from absolute event timestamps, not from a running counter.
  longint cycleNo     = 0;
  longint lastEvCycle = 0;
  bit     armed       = 0;
  int     mEvCnt      = 0;
  int     mLastOut    = 0;
  bit     mLocked     = 0;
  bit     mHavePrev   = 0;
  int     mPrev       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    armed     = 0;
    mEvCnt    = 0;
    mLastOut  = 0;
    mLocked   = 0;
    mHavePrev = 0;
    mPrev     = 0;
  endtask

  task automatic modelEdge(input bit ev);
    expect_t e;
    longint  p;
    int      enc;
    cycleNo++;
    if (ev) begin
      mEvCnt = (mEvCnt + 1) % 128;
      if (armed) begin
        p = cycleNo - lastEvCycle;
        e = '0;
        if (p > 256) begin
          e.err     = 1'b1;
          mLocked   = 0;
          mHavePrev = 0;
          mPrev     = 0;
        end else begin
          enc       = int'(p % 256);
          e.valid   = 1'b1;
          mLocked   = mHavePrev && (enc == mPrev);
          mPrev     = enc;
          mHavePrev = 1;
          mLastOut  = enc;
        end
        e.period = 8'(mLastOut);
        e.lock   = mLocked;
        e.evCnt  = 7'(mEvCnt);
        expQ.push_back(e);
      end
      armed       = 1;
      lastEvCycle = cycleNo;
    end
  endtask

  // Monitor: every strobe the DUT shows must match the oldest outstanding prediction.
  always @(negedge clk) begin
    expect_t e;
    if (!reset && (period_valid || period_err)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedStrobe: got valid=%0b err=%0b, expected no strobe",
                 period_valid, period_err);
      end else begin
        e = expQ.pop_front();
        check("strobeKind", {period_valid, period_err}, {e.valid, e.err});
        check("strobePeriod", period_out, e.period);
        check("strobeLocked", locked, e.lock);
        check("strobeEventCount", event_count, e.evCnt);
      end
    end
  end

  task automatic applyStimulus(input bit p);
    @(negedge clk);
    pulse_in = p;
    @(posedge clk);
    modelEdge(p);
  endtask

  task automatic sendEvents(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1);
      repeat (gap - 1) applyStimulus(1'b0);
    end
  endtask

  task automatic applyReset(input bit withPulse);
    repeat (3) applyStimulus(1'b0);
    check("queueDrainedBeforeReset", expQ.size(), 0);
    @(negedge clk);
    reset    = 1'b1;
    pulse_in = withPulse;
    @(posedge clk);
    cycleNo++;
    modelReset();
    #1;
    check("resetPeriod", period_out, 0);
    check("resetValid", period_valid, 0);
    check("resetErr", period_err, 0);
    check("resetLocked", locked, 0);
    check("resetEventCount", event_count, 0);
    @(negedge clk);
    reset    = 1'b0;
    pulse_in = 1'b0;
    @(posedge clk);
    modelEdge(1'b0);
  endtask

  task automatic checkOutput(input string tag);
    repeat (3) applyStimulus(1'b0);
    #1;
    check({tag, ".period"}, period_out, mLastOut);
    check({tag, ".locked"}, locked, mLocked);
    check({tag, ".eventCount"}, event_count, mEvCnt);
    check({tag, ".pending"}, expQ.size(), 0);
  endtask

  initial begin
    int lat;
    int r;
    int gap;
    reset    = 1'b1;
    pulse_in = 1'b0;
    applyReset(1'b0);

    sendEvents(3, 5);
    checkOutput("every5");
    check("every5.lockedSet", locked, 1);

    applyReset(1'b0);
    sendEvents(10, 1);
    checkOutput("heldHigh");
    check("heldHigh.count", event_count, 10);

    sendEvents(2, 256);
    checkOutput("period256");
    check("period256.encoded", period_out, 0);
    repeat (300 - 256 - 3) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("gap300");
    check("gap300.lockDropped", locked, 0);

    sendEvents(4, 7);
    sendEvents(1, 9);
    applyStimulus(1'b1);
    #1;
    check("relock.unlocked", locked, 0);
    check("relock.period9", period_out, 9);
    repeat (8) applyStimulus(1'b0);
    applyStimulus(1'b1);
    #1;
    check("relock.locked", locked, 1);

    applyReset(1'b0);
    sendEvents(130, 3);
    checkOutput("wrap");
    check("wrap.count", event_count, 2);

    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyReset(1'b1);
    applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);
    applyStimulus(1'b1);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (period_valid) begin
        lat = i;
        break;
      end
      applyStimulus(1'b0);
    end
    check("latency", lat, LAT_EXTRA);
    check("latencyPeriod", period_out, 4);
    checkOutput("afterLatency");

    for (int n = 0; n < 200; n++) begin
      r   = $urandom_range(0, 9);
      gap = (r < 8) ? $urandom_range(1, 12) : $urandom_range(250, 262);
      sendEvents(1, gap);
    end
    checkOutput("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
